biriscv_xu_ctrl: RTL and testbench

//  Non-blocking control for out-of-pipe long-latency units (divider, conv

---
 rtl/biriscv_xu_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_biriscv_xu_ctrl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/biriscv_xu_ctrl.sv
// Tracks outstanding ops of long-latency execution units, flags RAW/WAW hazards on their
// pending rd, and arbitrates unit results onto one register-file write port.
// Optional build macro BIRISCV_XU_BYPASS_EN: zero-latency writeback when the port is idle.
module biriscv_xu_ctrl #(
    parameter  int NUM_UNITS = 2,
    parameter  int DEPTH     = 4,
    parameter  int DATA_W    = 32,
    localparam int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        issue_valid_i,
    input  logic [UNIT_W-1:0]           issue_unit_i,
    input  logic [4:0]                  issue_rd_i,
    output logic                        issue_accept_o,
    input  logic [4:0]                  rs1_i,
    input  logic [4:0]                  rs2_i,
    output logic                        hazard_o,
    input  logic [NUM_UNITS-1:0]        unit_complete_i,
    input  logic [NUM_UNITS*DATA_W-1:0] unit_result_i,
    output logic [NUM_UNITS-1:0]        unit_ack_o,
    output logic                        wb_valid_o,
    output logic [4:0]                  wb_rd_o,
    output logic [DATA_W-1:0]           wb_result_o,
    input  logic                        wb_accept_i,
    output logic                        busy_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [4:0] rd_t;

    rd_t                             fifo_rd  [NUM_UNITS][DEPTH];
    logic [PTR_W-1:0]                rd_ptr_q [NUM_UNITS];
    logic [PTR_W-1:0]                wr_ptr_q [NUM_UNITS];
    logic [CNT_W-1:0]                count_q  [NUM_UNITS];
    logic [UNIT_W-1:0]               rr_q;
    logic                            wb_vld_q;
    rd_t                             wb_rd_q;
    logic [DATA_W-1:0]               wb_data_q;

    logic [NUM_UNITS-1:0][DEPTH-1:0] entry_vld;
    logic [PTR_W-1:0]                offs;
    logic                            hazard;
    logic                            waw;
    logic                            issue_full;
    logic [NUM_UNITS-1:0]            cand;
    logic [NUM_UNITS-1:0]            push;
    logic [NUM_UNITS-1:0]            pop;
    logic                            wb_free;
    logic                            gnt_any;
    logic [UNIT_W-1:0]               gnt_idx;
    logic [UNIT_W-1:0]               scan_idx;
    rd_t                             head_rd;
    logic [DATA_W-1:0]               head_data;
    logic                            bypass_take;
    logic                            wb_load;
    logic                            any_pending;

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        entry_vld = '0;
        offs      = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int i = 0; i < DEPTH; i++) begin
                offs = PTR_W'(i) - rd_ptr_q[u];
                entry_vld[u][i] = ({1'b0, offs} < count_q[u]);
            end
        end
    end

    always_comb begin
        hazard = 1'b0;
        waw    = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entry_vld[u][i]) begin
                    if ((rs1_i != '0 && fifo_rd[u][i] == rs1_i) ||
                        (rs2_i != '0 && fifo_rd[u][i] == rs2_i))
                        hazard = 1'b1;
                    if (UNIT_W'(u) != issue_unit_i && fifo_rd[u][i] == issue_rd_i)
                        waw = 1'b1;
                end
            end
        end
        if (wb_vld_q) begin
            if ((rs1_i != '0 && wb_rd_q == rs1_i) || (rs2_i != '0 && wb_rd_q == rs2_i))
                hazard = 1'b1;
            if (wb_rd_q == issue_rd_i)
                waw = 1'b1;
        end
        if (issue_rd_i == '0)
            waw = 1'b0;
    end

    // Full test uses the registered count, so a same-cycle pop never frees a slot.
    assign issue_full     = (count_q[issue_unit_i] == CNT_W'(DEPTH));
    assign issue_accept_o = ~rst_i & issue_valid_i & ~issue_full & ~waw;
    assign hazard_o       = hazard;
    assign wb_free        = ~wb_vld_q | wb_accept_i;

    always_comb begin
        push = '0;
        cand = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            push[u] = issue_accept_o & (issue_unit_i == UNIT_W'(u));
            cand[u] = unit_complete_i[u] & (count_q[u] != '0) & wb_free;
        end
    end

    // Round-robin scan starting at the unit after the last winner.
    always_comb begin
        gnt_any  = 1'b0;
        gnt_idx  = '0;
        scan_idx = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            scan_idx = UNIT_W'((int'(rr_q) + k) % NUM_UNITS);
            if (!gnt_any && cand[scan_idx]) begin
                gnt_any = 1'b1;
                gnt_idx = scan_idx;
            end
        end
    end

    always_comb begin
        pop       = '0;
        head_rd   = '0;
        head_data = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (gnt_any && gnt_idx == UNIT_W'(u)) begin
                pop[u]    = 1'b1;
                head_rd   = fifo_rd[u][rd_ptr_q[u]];
                head_data = unit_result_i[u*DATA_W +: DATA_W];
            end
        end
    end

    assign unit_ack_o = pop;

`ifdef BIRISCV_XU_BYPASS_EN
    assign bypass_take = gnt_any & (head_rd != '0) & ~wb_vld_q & wb_accept_i;
`else
    assign bypass_take = 1'b0;
`endif

    // Discard heads (rd=0) are popped and acked but never reach the write port.
    assign wb_load     = gnt_any & (head_rd != '0) & ~bypass_take;
    assign wb_valid_o  = wb_vld_q | bypass_take;
    assign wb_rd_o     = bypass_take ? head_rd : wb_rd_q;
    assign wb_result_o = bypass_take ? head_data : wb_data_q;

    always_comb begin
        any_pending = 1'b0;
        for (int u = 0; u < NUM_UNITS; u++)
            if (count_q[u] != '0)
                any_pending = 1'b1;
    end

    assign busy_o = any_pending | wb_valid_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst_i) begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                rd_ptr_q[u] <= '0;
                wr_ptr_q[u] <= '0;
                count_q[u]  <= '0;
            end
            rr_q      <= '0;
            wb_vld_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
        end else begin
            for (int u = 0; u < NUM_UNITS; u++) begin
                if (push[u])
                    wr_ptr_q[u] <= wr_ptr_q[u] + 1'b1;
                if (pop[u])
                    rd_ptr_q[u] <= rd_ptr_q[u] + 1'b1;
                count_q[u] <= count_q[u] + CNT_W'(push[u]) - CNT_W'(pop[u]);
            end
            if (gnt_any)
                rr_q <= (gnt_idx == UNIT_W'(NUM_UNITS - 1)) ? '0 : gnt_idx + 1'b1;
            if (wb_load) begin
                wb_vld_q  <= 1'b1;
                wb_rd_q   <= head_rd;
                wb_data_q <= head_data;
            end else if (wb_accept_i) begin
                wb_vld_q  <= 1'b0;
            end
        end
    end

    // NOTE: tag storage is not reset; liveness comes only from the reset pointers and counts.
    always_ff @(posedge clk_i) begin
        for (int u = 0; u < NUM_UNITS; u++)
            if (push[u])
                fifo_rd[u][wr_ptr_q[u]] <= issue_rd_i;
    end

endmodule

// File: tb/tb_biriscv_xu_ctrl.sv
// Self-checking bench for biriscv_xu_ctrl (default build): directed scenarios with fixed
// expectations plus a randomized run against a queue-based reference model.
module tb_biriscv_xu_ctrl;

    localparam int NU    = 2;
    localparam int DEPTH = 4;
    localparam int DW    = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              issue_valid_i;
    logic [0:0]        issue_unit_i;
    logic [4:0]        issue_rd_i;
    logic              issue_accept_o;
    logic [4:0]        rs1_i;
    logic [4:0]        rs2_i;
    logic              hazard_o;
    logic [NU-1:0]     unit_complete_i;
    logic [NU*DW-1:0]  unit_result_i;
    logic [NU-1:0]     unit_ack_o;
    logic              wb_valid_o;
    logic [4:0]        wb_rd_o;
    logic [DW-1:0]     wb_result_o;
    logic              wb_accept_i;
    logic              busy_o;

    int n_checks;
    int n_fail;

    biriscv_xu_ctrl #(.NUM_UNITS(NU), .DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .issue_valid_i   (issue_valid_i),
        .issue_unit_i    (issue_unit_i),
        .issue_rd_i      (issue_rd_i),
        .issue_accept_o  (issue_accept_o),
        .rs1_i           (rs1_i),
        .rs2_i           (rs2_i),
        .hazard_o        (hazard_o),
        .unit_complete_i (unit_complete_i),
        .unit_result_i   (unit_result_i),
        .unit_ack_o      (unit_ack_o),
        .wb_valid_o      (wb_valid_o),
        .wb_rd_o         (wb_rd_o),
        .wb_result_o     (wb_result_o),
        .wb_accept_i     (wb_accept_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: one in-order queue of rd per unit plus the single writeback slot.
    logic [4:0]    mq [NU][$];
    logic          m_wb_v;
    logic [4:0]    m_wb_rd;
    logic [DW-1:0] m_wb_data;
    int            m_rr;

    logic          exp_accept;
    logic          exp_hazard;
    logic [NU-1:0] exp_ack;
    logic          exp_busy;
    int            exp_gnt;

    task automatic model_reset();
        for (int u = 0; u < NU; u++) mq[u].delete();
        m_wb_v = 1'b0; m_wb_rd = '0; m_wb_data = '0; m_rr = 0;
    endtask

    function automatic bit is_pending(logic [4:0] r);
        if (r == 0) return 1'b0;
        for (int u = 0; u < NU; u++)
            for (int i = 0; i < mq[u].size(); i++)
                if (mq[u][i] == r) return 1'b1;
        return m_wb_v && (m_wb_rd == r);
    endfunction

    task automatic model_eval();
        bit waw;
        int u;
        waw = 1'b0;
        if (issue_rd_i != 0) begin
            for (int v = 0; v < NU; v++)
                if (v != int'(issue_unit_i))
                    for (int i = 0; i < mq[v].size(); i++)
                        if (mq[v][i] == issue_rd_i) waw = 1'b1;
            if (m_wb_v && m_wb_rd == issue_rd_i) waw = 1'b1;
        end
        exp_accept = !rst_i && issue_valid_i && (mq[issue_unit_i].size() < DEPTH) && !waw;
        exp_hazard = is_pending(rs1_i) || is_pending(rs2_i);
        exp_gnt = -1;
        if (!rst_i && (!m_wb_v || wb_accept_i))
            for (int k = 0; k < NU; k++) begin
                u = (m_rr + k) % NU;
                if (exp_gnt < 0 && unit_complete_i[u] && mq[u].size() > 0) exp_gnt = u;
            end
        exp_ack = (exp_gnt >= 0) ? NU'(1 << exp_gnt) : '0;
        exp_busy = m_wb_v;
        for (int v = 0; v < NU; v++) if (mq[v].size() > 0) exp_busy = 1'b1;
    endtask

    task automatic model_commit();
        logic [4:0] head;
        if (rst_i) begin
            model_reset();
            return;
        end
        if (m_wb_v && wb_accept_i) m_wb_v = 1'b0;
        if (exp_gnt >= 0) begin
            head = mq[exp_gnt].pop_front();
            if (head != 0) begin
                m_wb_v = 1'b1; m_wb_rd = head; m_wb_data = unit_result_i[exp_gnt*DW +: DW];
            end
            m_rr = (exp_gnt + 1) % NU;
        end
        if (exp_accept) mq[issue_unit_i].push_back(issue_rd_i);
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk_i);
        model_commit();
        #1;
    endtask

    task automatic clear_inputs();
        issue_valid_i = 0; issue_unit_i = 0; issue_rd_i = 0; rs1_i = 0; rs2_i = 0;
        unit_complete_i = 0; unit_result_i = 0; wb_accept_i = 0;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        rst_i = 1'b1;
        issue_valid_i = 1; issue_rd_i = 3; unit_complete_i = 2'b11; wb_accept_i = 1; rs1_i = 3;
        #1;
        n_checks++; if (issue_accept_o !== 1'b0) begin n_fail++; $display("FAIL rst_accept got %b want 0", issue_accept_o); end
        n_checks++; if (unit_ack_o !== 2'b00) begin n_fail++; $display("FAIL rst_ack got %b want 00", unit_ack_o); end
        n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_wb_valid got %b want 0", wb_valid_o); end
        n_checks++; if (wb_rd_o !== 5'd0 || wb_result_o !== 32'd0) begin n_fail++; $display("FAIL rst_wb_data got rd=%0d data=%h want 0/0", wb_rd_o, wb_result_o); end
        n_checks++; if (hazard_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_hazard_busy got %b/%b want 0/0", hazard_o, busy_o); end
        tick();
        rst_i = 1'b0;
        clear_inputs();
    endtask

    task automatic test_single();
        apply_reset();
        wb_accept_i = 1;
        issue_valid_i = 1; issue_unit_i = 0; issue_rd_i = 5; rs1_i = 5;
        #1;
        n_checks++; if (issue_accept_o !== 1'b1) begin n_fail++; $display("FAIL t1_accept got %b want 1", issue_accept_o); end
        n_checks++; if (hazard_o !== 1'b0) begin n_fail++; $display("FAIL t1_hazard_before got %b want 0", hazard_o); end
        tick();
        issue_valid_i = 0;
        for (int c = 0; c < 9; c++) begin
            #1;
            n_checks++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL t2_hazard_pending cyc %0d got %b want 1", c, hazard_o); end
            n_checks++; if (busy_o !== 1'b1 || wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL t1_waiting cyc %0d busy=%b wb_valid=%b want 1/0", c, busy_o, wb_valid_o); end
            tick();
        end
        unit_complete_i = 2'b01; unit_result_i[31:0] = 32'h1234;
        #1;
        n_checks++; if (unit_ack_o !== 2'b01) begin n_fail++; $display("FAIL t1_ack got %b want 01", unit_ack_o); end
        n_checks++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL t2_hazard_grant_cycle got %b want 1", hazard_o); end
        tick();
        unit_complete_i = 0;
        #1;
        n_checks++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd5 || wb_result_o !== 32'h1234) begin n_fail++; $display("FAIL t1_wb got v=%b rd=%0d data=%h want 1/5/1234", wb_valid_o, wb_rd_o, wb_result_o); end
        n_checks++; if (unit_ack_o !== 2'b00) begin n_fail++; $display("FAIL t1_ack_drop got %b want 00", unit_ack_o); end
        tick();
        #1;
        n_checks++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b0 || hazard_o !== 1'b0) begin n_fail++; $display("FAIL t1_idle got v=%b busy=%b hz=%b want 0/0/0", wb_valid_o, busy_o, hazard_o); end
        rs1_i = 0;
    endtask

    task automatic test_full();
        apply_reset();
        wb_accept_i = 1; issue_valid_i = 1; issue_unit_i = 1;
        for (int r = 1; r <= 4; r++) begin
            issue_rd_i = 5'(r);
            #1;
            n_checks++; if (issue_accept_o !== 1'b1) begin n_fail++; $display("FAIL t3_fill rd=%0d got %b want 1", r, issue_accept_o); end
            tick();
        end
        issue_rd_i = 5;
        #1;
        n_checks++; if (issue_accept_o !== 1'b0) begin n_fail++; $display("FAIL t3_full_reject got %b want 0", issue_accept_o); end
        tick();
        unit_complete_i = 2'b10; unit_result_i[63:32] = 32'hA001;
        #1;
        n_checks++; if (issue_accept_o !== 1'b0) begin n_fail++; $display("FAIL t3_same_cycle_pop got %b want 0", issue_accept_o); end
        n_checks++; if (unit_ack_o !== 2'b10) begin n_fail++; $display("FAIL t3_first_ack got %b want 10", unit_ack_o); end
        tick();
        unit_complete_i = 0;
        #1;
        n_checks++; if (issue_accept_o !== 1'b1) begin n_fail++; $display("FAIL t3_space_freed got %b want 1", issue_accept_o); end
        n_checks++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd1 || wb_result_o !== 32'hA001) begin n_fail++; $display("FAIL t3_wb1 got v=%b rd=%0d data=%h want 1/1/a001", wb_valid_o, wb_rd_o, wb_result_o); end
        tick();
        issue_valid_i = 0;
        for (int k = 2; k <= 5; k++) begin
            unit_complete_i = 2'b10; unit_result_i[63:32] = 32'hA000 + 32'(k);
            #1;
            n_checks++; if (unit_ack_o !== 2'b10) begin n_fail++; $display("FAIL t3_ack k=%0d got %b want 10", k, unit_ack_o); end
            if (k > 2) begin
                n_checks++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'(k - 1) || wb_result_o !== 32'hA000 + 32'(k - 1)) begin n_fail++; $display("FAIL t3_order k=%0d got v=%b rd=%0d data=%h want rd %0d", k, wb_valid_o, wb_rd_o, wb_result_o, k - 1); end
            end else begin
                n_checks++; if (wb_valid_o !== 1'b0) begin n_fail++; $display("FAIL t3_gap got %b want 0", wb_valid_o); end
            end
            tick();
        end
        unit_complete_i = 0;
        #1;
        n_checks++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd5 || wb_result_o !== 32'hA005) begin n_fail++; $display("FAIL t3_last got v=%b rd=%0d data=%h want 1/5/a005", wb_valid_o, wb_rd_o, wb_result_o); end
        tick();
        #1;
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL t3_drained busy got %b want 0", busy_o); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  ack_want [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [4:0]  rd_want  [4] = '{5'd10, 5'd11, 5'd12, 5'd13};
        logic [31:0] dat_want [4] = '{32'hD00A, 32'hC00B, 32'hD00C, 32'hC00D};
        apply_reset();
        wb_accept_i = 1; issue_valid_i = 1;
        for (int i = 0; i < 4; i++) begin
            issue_unit_i = 1'(i % 2); issue_rd_i = rd_want[i];
            #1;
            n_checks++; if (issue_accept_o !== 1'b1) begin n_fail++; $display("FAIL t4_issue %0d got %b want 1", i, issue_accept_o); end
            tick();
        end
        issue_valid_i = 0;
        unit_complete_i = 2'b11; unit_result_i = {32'hC00B, 32'hD00A};
        for (int c = 0; c < 5; c++) begin
            if (c == 1) unit_result_i[31:0] = 32'hD00C;
            if (c == 2) unit_result_i[63:32] = 32'hC00D;
            if (c == 3) unit_complete_i = 2'b10;
            if (c == 4) unit_complete_i = 2'b00;
            #1;
            n_checks++; if (unit_ack_o !== ((c < 4) ? ack_want[c] : 2'b00)) begin n_fail++; $display("FAIL t4_rr_ack cyc %0d got %b", c, unit_ack_o); end
            if (c > 0) begin
                n_checks++; if (wb_valid_o !== 1'b1 || wb_rd_o !== rd_want[c-1] || wb_result_o !== dat_want[c-1]) begin n_fail++; $display("FAIL t4_rr_wb cyc %0d got v=%b rd=%0d data=%h want rd %0d", c, wb_valid_o, wb_rd_o, wb_result_o, rd_want[c-1]); end
            end
            tick();
        end
        #1;
        n_checks++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL t4_idle got v=%b busy=%b want 0/0", wb_valid_o, busy_o); end
    endtask

    task automatic test_stall();
        apply_reset();
        issue_valid_i = 1; issue_unit_i = 0; issue_rd_i = 20;
        tick();
        issue_unit_i = 1; issue_rd_i = 21;
        tick();
        issue_valid_i = 0;
        wb_accept_i = 0; unit_complete_i = 2'b11; unit_result_i = {32'h2121, 32'h2020};
        #1;
        n_checks++; if (unit_ack_o !== 2'b01) begin n_fail++; $display("FAIL t5_first_ack got %b want 01", unit_ack_o); end
        tick();
        unit_complete_i = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd20 || wb_result_o !== 32'h2020) begin n_fail++; $display("FAIL t5_hold cyc %0d got v=%b rd=%0d data=%h", c, wb_valid_o, wb_rd_o, wb_result_o); end
            n_checks++; if (unit_ack_o !== 2'b00) begin n_fail++; $display("FAIL t5_no_ack cyc %0d got %b want 00", c, unit_ack_o); end
            tick();
        end
        wb_accept_i = 1;
        #1;
        n_checks++; if (unit_ack_o !== 2'b10) begin n_fail++; $display("FAIL t5_release_ack got %b want 10", unit_ack_o); end
        tick();
        unit_complete_i = 0;
        #1;
        n_checks++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd21 || wb_result_o !== 32'h2121) begin n_fail++; $display("FAIL t5_second got v=%b rd=%0d data=%h want 1/21/2121", wb_valid_o, wb_rd_o, wb_result_o); end
        tick();
    endtask

    task automatic test_discard_waw_reset();
        apply_reset();
        wb_accept_i = 1;
        issue_valid_i = 1; issue_unit_i = 1; issue_rd_i = 0;
        #1;
        n_checks++; if (issue_accept_o !== 1'b1) begin n_fail++; $display("FAIL t6_discard_issue got %b want 1", issue_accept_o); end
        tick();
        issue_valid_i = 0; unit_complete_i = 2'b10; unit_result_i[63:32] = 32'hDEAD;
        #1;
        n_checks++; if (unit_ack_o !== 2'b10) begin n_fail++; $display("FAIL t6_discard_ack got %b want 10", unit_ack_o); end
        tick();
        unit_complete_i = 0;
        #1;
        n_checks++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL t6_discard_wb got v=%b busy=%b want 0/0", wb_valid_o, busy_o); end
        issue_valid_i = 1; issue_unit_i = 0; issue_rd_i = 7;
        tick();
        issue_unit_i = 1;
        #1;
        n_checks++; if (issue_accept_o !== 1'b0) begin n_fail++; $display("FAIL t6_waw_block got %b want 0", issue_accept_o); end
        tick();
        issue_unit_i = 0;
        #1;
        n_checks++; if (issue_accept_o !== 1'b1) begin n_fail++; $display("FAIL t6_same_unit_ok got %b want 1", issue_accept_o); end
        tick();
        issue_unit_i = 1; issue_rd_i = 9;
        tick();
        issue_valid_i = 0; rs2_i = 9;
        #1;
        n_checks++; if (hazard_o !== 1'b1) begin n_fail++; $display("FAIL t6_rs2_hazard got %b want 1", hazard_o); end
        wb_accept_i = 0; unit_complete_i = 2'b01; unit_result_i[31:0] = 32'h7777;
        tick();
        unit_complete_i = 0;
        #1;
        n_checks++; if (wb_valid_o !== 1'b1 || wb_rd_o !== 5'd7) begin n_fail++; $display("FAIL t6_wb_loaded got v=%b rd=%0d want 1/7", wb_valid_o, wb_rd_o); end
        rst_i = 1'b1; unit_complete_i = 2'b11; issue_valid_i = 1; issue_rd_i = 3; rs1_i = 7;
        #1;
        n_checks++; if (wb_valid_o !== 1'b0 || wb_rd_o !== 5'd0 || wb_result_o !== 32'd0) begin n_fail++; $display("FAIL t6_rst_wb got v=%b rd=%0d data=%h want 0", wb_valid_o, wb_rd_o, wb_result_o); end
        n_checks++; if (unit_ack_o !== 2'b00 || issue_accept_o !== 1'b0) begin n_fail++; $display("FAIL t6_rst_handshake got ack=%b acc=%b want 00/0", unit_ack_o, issue_accept_o); end
        n_checks++; if (hazard_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL t6_rst_state got hz=%b busy=%b want 0/0", hazard_o, busy_o); end
        tick();
        rst_i = 1'b0;
        clear_inputs();
        wb_accept_i = 1;
        for (int c = 0; c < 4; c++) begin
            #1;
            n_checks++; if (wb_valid_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL t6_after_rst cyc %0d got v=%b busy=%b", c, wb_valid_o, busy_o); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [NU-1:0] acked_last;
        apply_reset();
        acked_last = '0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            issue_valid_i = 1'($urandom_range(0, 1));
            issue_unit_i  = 1'($urandom_range(0, 1));
            issue_rd_i    = 5'($urandom_range(0, 7));
            rs1_i         = 5'($urandom_range(0, 7));
            rs2_i         = 5'($urandom_range(0, 7));
            wb_accept_i   = ($urandom_range(0, 9) < 7);
            for (int n = 0; n < NU; n++) begin
                if (acked_last[n]) unit_complete_i[n] = 1'b0;
                if (!unit_complete_i[n]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        unit_complete_i[n] = 1'b1;
                        unit_result_i[n*DW +: DW] = $urandom;
                    end
                end else if (mq[n].size() == 0 && $urandom_range(0, 1) == 1) begin
                    unit_complete_i[n] = 1'b0;
                end
            end
            #1;
            model_eval();
            n_checks++; if (issue_accept_o !== exp_accept) begin n_fail++; $display("FAIL rnd_accept cyc %0d got %b want %b", cyc, issue_accept_o, exp_accept); end
            n_checks++; if (hazard_o !== exp_hazard) begin n_fail++; $display("FAIL rnd_hazard cyc %0d got %b want %b", cyc, hazard_o, exp_hazard); end
            n_checks++; if (unit_ack_o !== exp_ack) begin n_fail++; $display("FAIL rnd_ack cyc %0d got %b want %b", cyc, unit_ack_o, exp_ack); end
            n_checks++; if (wb_valid_o !== m_wb_v) begin n_fail++; $display("FAIL rnd_wb_valid cyc %0d got %b want %b", cyc, wb_valid_o, m_wb_v); end
            if (m_wb_v) begin
                n_checks++; if (wb_rd_o !== m_wb_rd || wb_result_o !== m_wb_data) begin n_fail++; $display("FAIL rnd_wb_data cyc %0d got rd=%0d data=%h want rd=%0d data=%h", cyc, wb_rd_o, wb_result_o, m_wb_rd, m_wb_data); end
            end
            n_checks++; if (busy_o !== exp_busy) begin n_fail++; $display("FAIL rnd_busy cyc %0d got %b want %b", cyc, busy_o, exp_busy); end
            acked_last = exp_ack;
            tick();
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_i    = 1'b1;
        clear_inputs();
        model_reset();
        test_reset();
        test_single();
        test_full();
        test_round_robin();
        test_stall();
        test_discard_waw_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
